// File: rtl/fp_d_wb_stage.sv
// fp_d_wb_stage: FP64 sqrt/div writeback with NaN canonicalisation, IEEE flags,
// 2-entry valid/ready skid buffer, sticky fflags and a retired-op counter.
module fp_d_wb_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [63:0]      in_src_a,
  input  logic [63:0]      in_src_b,
  input  logic [63:0]      in_result,
  input  logic             in_nx,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [63:0]      out_data,
  output logic [4:0]       out_flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

  // {nan, snan, inf, zero}; the sign bit plays no part
  function automatic logic [3:0] classify(input logic [62:0] v);
    logic exp_max;
    logic exp_zero;
    logic frac_zero;
    exp_max   = &v[62:52];
    exp_zero  = ~|v[62:52];
    frac_zero = ~|v[51:0];
    classify  = {exp_max & ~frac_zero,
                 exp_max & ~frac_zero & ~v[51],
                 exp_max & frac_zero,
                 exp_zero & frac_zero};
  endfunction

  logic [3:0] w_cls_a;
  logic [3:0] w_cls_b;
  logic [3:0] w_cls_r;
  logic       w_a_nan, w_a_snan, w_a_inf, w_a_zero;
  logic       w_b_nan, w_b_snan, w_b_inf, w_b_zero;
  logic       w_r_nan, w_r_inf;
  logic       w_r_sub;
  logic       w_op_sqrt;
  logic       w_op_div;
  logic       w_nv, w_dz, w_of, w_uf, w_nx;
  logic [4:0] w_flags;
  logic [63:0] w_data;
  logic       w_in_hs;
  logic       w_out_hs;

  assign w_cls_a = classify(in_src_a[62:0]);
  assign w_cls_b = classify(in_src_b[62:0]);
  assign w_cls_r = classify(in_result[62:0]);

  assign {w_a_nan, w_a_snan, w_a_inf, w_a_zero} = w_cls_a;
  assign {w_b_nan, w_b_snan, w_b_inf, w_b_zero} = w_cls_b;
  assign w_r_nan = w_cls_r[3];
  assign w_r_inf = w_cls_r[1];
  assign w_r_sub = ~|in_result[62:52] & |in_result[51:0];

  assign w_op_sqrt = (in_op == 2'd0);
  assign w_op_div  = (in_op == 2'd1);

  assign w_nv =
    (w_op_sqrt & (w_a_snan |
                  (in_src_a[63] & ~w_a_zero & ~w_a_nan))) |
    (w_op_div  & (w_a_snan | w_b_snan |
                  (w_a_zero & w_b_zero) |
                  (w_a_inf & w_b_inf)));

  assign w_dz = w_op_div & w_b_zero &
                ~w_a_zero & ~w_a_inf & ~w_a_nan;

  // overflow only when an infinity was produced from finite operands
  assign w_of = w_r_inf & (w_op_sqrt | w_op_div) & ~w_a_inf &
                ~(w_op_div & (w_b_inf | w_dz));

  assign w_uf = w_r_sub & in_nx;
  assign w_nx = (in_nx | w_of) & ~w_nv & ~w_dz;

  assign w_flags = {w_nv, w_dz, w_of, w_uf, w_nx};
  assign w_data  = (w_r_nan | w_nv) ? CANON_NAN : in_result;

  state_t      r_state;
  logic        r_valid;
  logic        r_rdy;
  logic [4:0]  r_m_rd;
  logic [63:0] r_m_data;
  logic [4:0]  r_m_flags;
  logic [4:0]  r_s_rd;
  logic [63:0] r_s_data;
  logic [4:0]  r_s_flags;
  logic [4:0]  r_fflags;
  logic [CNT_W-1:0] r_retired;

  assign w_in_hs  = in_valid & r_rdy;
  assign w_out_hs = r_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_valid   <= 1'b0;
      r_rdy     <= 1'b1;
      r_m_rd    <= '0;
      r_m_data  <= '0;
      r_m_flags <= '0;
      r_s_rd    <= '0;
      r_s_data  <= '0;
      r_s_flags <= '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_hs) begin
            r_m_rd    <= in_rd;
            r_m_data  <= w_data;
            r_m_flags <= w_flags;
            r_valid   <= 1'b1;
            r_state   <= S_ONE;
          end
        end
        S_ONE: begin
          unique case ({w_in_hs, w_out_hs})
            2'b10: begin
              r_s_rd    <= in_rd;
              r_s_data  <= w_data;
              r_s_flags <= w_flags;
              r_rdy     <= 1'b0;
              r_state   <= S_FULL;
            end
            2'b01: begin
              r_valid <= 1'b0;
              r_state <= S_EMPTY;
            end
            2'b11: begin
              r_m_rd    <= in_rd;
              r_m_data  <= w_data;
              r_m_flags <= w_flags;
            end
            default: ;
          endcase
        end
        S_FULL: begin
          if (w_out_hs) begin
            r_m_rd    <= r_s_rd;
            r_m_data  <= r_s_data;
            r_m_flags <= r_s_flags;
            r_rdy     <= 1'b1;
            r_state   <= S_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // a clear coinciding with a retirement keeps that packet's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags  <= '0;
      r_retired <= '0;
    end else begin
      if (w_out_hs) begin
        r_fflags  <= (fflags_clr ? 5'd0 : r_fflags) | r_m_flags;
        r_retired <= r_retired + 1'b1;
      end else if (fflags_clr) begin
        r_fflags <= '0;
      end
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = r_valid;
  assign out_rd    = r_m_rd;
  assign out_data  = r_m_data;
  assign out_flags = r_m_flags;
  assign fflags    = r_fflags;
  assign retired   = r_retired;

endmodule

// File: tb/tb_fp_d_wb_stage.sv
// tb_fp_d_wb_stage: vector table plus scoreboard queue for fp_d_wb_stage,
// with directed stall, fflags-clear, reset-while-full and counter-wrap cases.
module tb_fp_d_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_src_a;
  logic [63:0] in_src_b;
  logic [63:0] in_result;
  logic        in_nx;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic [15:0] retired;

  fp_d_wb_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_result(in_result), .in_nx(in_nx), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .out_flags(out_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        nx;
    logic [63:0] ed;
    logic [4:0]  ef;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
    logic [4:0]  f;
  } exp_t;

  localparam int NV = 14;
  localparam logic [63:0] CN = 64'h7FF8000000000000;

  vec_t tv [NV];
  exp_t q [$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   sb_en = 1'b1;
  logic [4:0]  e_rd;
  logic [63:0] e_data;
  logic [4:0]  e_flags;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
          chk("sb_data", out_data, e.d);
          chk("sb_flags", {59'd0, out_flags}, {59'd0, e.f});
        end
      end
      if (in_valid && in_ready)
        q.push_back('{e_rd, e_data, e_flags});
    end
  end

  task automatic drive(input int i, input logic [4:0] rd);
    in_op     = tv[i].op;
    in_src_a  = tv[i].a;
    in_src_b  = tv[i].b;
    in_result = tv[i].r;
    in_nx     = tv[i].nx;
    in_rd     = rd;
    e_rd      = rd;
    e_data    = tv[i].ed;
    e_flags   = tv[i].ef;
  endtask

  task automatic send(input int i, input logic [4:0] rd);
    bit ok;
    drive(i, rd);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!out_valid && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{2'd0, 64'h4022000000000000, 64'h0,
               64'h4008000000000000, 1'b0, 64'h4008000000000000, 5'b00000};
    tv[1]  = '{2'd0, 64'hBFF0000000000000, 64'h0,
               64'h7FF8000000000000, 1'b0, CN, 5'b10000};
    tv[2]  = '{2'd0, 64'h7FF0000000000001, 64'h0,
               64'h7FF8000000000001, 1'b0, CN, 5'b10000};
    tv[3]  = '{2'd1, 64'h3FF0000000000000, 64'h0,
               64'h7FF0000000000000, 1'b0, 64'h7FF0000000000000, 5'b01000};
    tv[4]  = '{2'd1, 64'h0, 64'h0,
               64'h7FF8000000000000, 1'b0, CN, 5'b10000};
    tv[5]  = '{2'd1, 64'h3FF0000000000000, 64'h4000000000000000,
               64'h3FE0000000000000, 1'b0, 64'h3FE0000000000000, 5'b00000};
    tv[6]  = '{2'd0, 64'h7FF0000000000000, 64'h0,
               64'h7FF0000000000000, 1'b0, 64'h7FF0000000000000, 5'b00000};
    tv[7]  = '{2'd1, 64'h7FE0000000000000, 64'h3FE0000000000000,
               64'h7FF0000000000000, 1'b1, 64'h7FF0000000000000, 5'b00101};
    tv[8]  = '{2'd2, 64'hFFF0000000000001, 64'h0,
               64'h0000000000000001, 1'b1, 64'h0000000000000001, 5'b00011};
    tv[9]  = '{2'd0, 64'h8000000000000000, 64'h0,
               64'h8000000000000000, 1'b0, 64'h8000000000000000, 5'b00000};
    tv[10] = '{2'd2, 64'h0, 64'h0,
               64'h7FF4000000000000, 1'b0, CN, 5'b00000};
    tv[11] = '{2'd1, 64'h7FF0000000000000, 64'h7FF0000000000000,
               64'h7FF8000000000000, 1'b0, CN, 5'b10000};
    tv[12] = '{2'd1, 64'h7FF8000000000000, 64'h0,
               64'h7FF8000000000000, 1'b0, CN, 5'b00000};
    tv[13] = '{2'd3, 64'hBFF0000000000000, 64'h0,
               64'h4000000000000000, 1'b1, 64'h4000000000000000, 5'b00001};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
    drive(0, 5'd0);
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_rd", {59'd0, out_rd}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_flags", {59'd0, out_flags}, 64'd0);
    chk("rst_fflags", {59'd0, fflags}, 64'd0);
    chk("rst_retired", {48'd0, retired}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    send(0, 5'd3);
    @(negedge clk);
    chk("latency_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    chk("retired_1", {48'd0, retired}, 64'd1);
    send(1, 5'd4);
    send(2, 5'd5);
    wait_drain();
    chk("fflags_nv", {59'd0, fflags}, 64'b10000);

    for (int i = 0; i < NV; i++) begin
      drive(i, 5'(i + 1));
      in_valid = 1'b1;
      @(negedge clk);
      chk("thru_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    chk("retired_thru", {48'd0, retired}, 64'(3 + NV));

    out_ready = 1'b0;
    drive(5, 5'd1); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(7, 5'd2);
    @(posedge clk); #1;
    drive(8, 5'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_data", out_data, tv[5].ed);
      chk("stall_rd", {59'd0, out_rd}, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("stall_release", 64'd1, 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("fflags_clr", {59'd0, fflags}, 64'd0);
    send(1, 5'd6);
    send(13, 5'd7);
    wait_drain();
    chk("fflags_acc", {59'd0, fflags}, 64'b10001);
    send(7, 5'd8);
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("fflags_clr_acc", {59'd0, fflags}, 64'b00101);
    wait_drain();

    out_ready = 1'b0;
    drive(0, 5'd9); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(5, 5'd10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    chk("full_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_rd", {59'd0, out_rd}, 64'd0);
    chk("arst_flags", {59'd0, out_flags}, 64'd0);
    chk("arst_fflags", {59'd0, fflags}, 64'd0);
    chk("arst_retired", {48'd0, retired}, 64'd0);
    chk("arst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_flushed", {63'd0, out_valid}, 64'd0);

    sb_en = 1'b0;
    drive(0, 5'd1);
    in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();
    chk("retired_max", {48'd0, retired}, 64'hFFFF);
    send(0, 5'd2);
    wait_drain();
    chk("retired_wrap", {48'd0, retired}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
